// File: rtl/filter_arbiter_pkg.sv
// Shared filter constants: default sizing, pair word layout and field offsets.
// Used by the filter, arbiter and force-pipeline blocks.
package filter_arbiter_pkg;

    localparam int NUM_FILTER_DEFAULT        = 4;
    localparam int PARTICLE_ID_WIDTH_DEFAULT = 20;
    localparam int DATA_WIDTH_DEFAULT        = 32;
    localparam int PAIR_COUNT_WIDTH          = 32;

    // Pair word, MSB to LSB: {ref_id, neighbor_id, r2, dz, dy, dx}
    function automatic int pairWidth(input int idWidth, input int dataWidth);
        return 2 * idWidth + 4 * dataWidth;
    endfunction

    function automatic int dyLsb(input int dataWidth);
        return dataWidth;
    endfunction

    function automatic int dzLsb(input int dataWidth);
        return 2 * dataWidth;
    endfunction

    function automatic int r2Lsb(input int dataWidth);
        return 3 * dataWidth;
    endfunction

    function automatic int neighborLsb(input int dataWidth);
        return 4 * dataWidth;
    endfunction

    function automatic int refLsb(input int idWidth, input int dataWidth);
        return 4 * dataWidth + idWidth;
    endfunction

    localparam int DX_LSB             = 0;
    localparam int PAIR_WIDTH_DEFAULT = pairWidth(PARTICLE_ID_WIDTH_DEFAULT, DATA_WIDTH_DEFAULT);
    localparam int DY_LSB_DEFAULT     = dyLsb(DATA_WIDTH_DEFAULT);
    localparam int DZ_LSB_DEFAULT     = dzLsb(DATA_WIDTH_DEFAULT);
    localparam int R2_LSB_DEFAULT     = r2Lsb(DATA_WIDTH_DEFAULT);
    localparam int NBR_LSB_DEFAULT    = neighborLsb(DATA_WIDTH_DEFAULT);
    localparam int REF_LSB_DEFAULT    = refLsb(PARTICLE_ID_WIDTH_DEFAULT, DATA_WIDTH_DEFAULT);

    typedef struct packed {
        logic [PARTICLE_ID_WIDTH_DEFAULT-1:0] refId;
        logic [PARTICLE_ID_WIDTH_DEFAULT-1:0] neighborId;
        logic [DATA_WIDTH_DEFAULT-1:0]        r2;
        logic [DATA_WIDTH_DEFAULT-1:0]        dz;
        logic [DATA_WIDTH_DEFAULT-1:0]        dy;
        logic [DATA_WIDTH_DEFAULT-1:0]        dx;
    } pair_t;

endpackage

// File: rtl/filter_arbiter_rr_priority_picker.sv
// Round-robin find-first: grants the first set request at or above the pointer,
// wrapping from the top index back to zero.
module rr_priority_picker
    import filter_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = NUM_FILTER_DEFAULT,
    localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   i_request,
    input  logic [IDX_WIDTH-1:0] i_pointer,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [IDX_WIDTH-1:0] o_grantIdx
);

    logic                 w_found;
    logic [IDX_WIDTH-1:0] w_cand;

    always_comb begin
        o_grant    = '0;
        o_grantIdx = '0;
        w_found    = 1'b0;
        w_cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_WIDTH'((int'(i_pointer) + k) % NUM_REQ);
            if (!w_found && i_request[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grantIdx      = w_cand;
            end
        end
    end

endmodule

// File: rtl/filter_arbiter.sv
// Round-robin arbiter feeding one force pipeline from several filter pair buffers,
// with a read stage and an output stage (sel to pair_valid is two cycles).
module filter_arbiter
    import filter_arbiter_pkg::*;
#(
    parameter  int NUM_FILTER        = NUM_FILTER_DEFAULT,
    parameter  int PARTICLE_ID_WIDTH = PARTICLE_ID_WIDTH_DEFAULT,
    parameter  int DATA_WIDTH        = DATA_WIDTH_DEFAULT,
    localparam int PAIR_WIDTH        = pairWidth(PARTICLE_ID_WIDTH, DATA_WIDTH),
    localparam int IDX_WIDTH         = $clog2(NUM_FILTER)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_FILTER-1:0]            particle_pair_available,
    input  logic [NUM_FILTER*PAIR_WIDTH-1:0] filter_pair_data,
    output logic [NUM_FILTER-1:0]            sel,
    input  logic                             pipeline_stall,
    output logic [PARTICLE_ID_WIDTH-1:0]     ref_particle_id_out,
    output logic [PARTICLE_ID_WIDTH-1:0]     neighbor_particle_id_out,
    output logic [DATA_WIDTH-1:0]            r2_out,
    output logic [DATA_WIDTH-1:0]            dx_out,
    output logic [DATA_WIDTH-1:0]            dy_out,
    output logic [DATA_WIDTH-1:0]            dz_out,
    output logic                             pair_valid,
    output logic [IDX_WIDTH-1:0]             source_filter,
    output logic [PAIR_COUNT_WIDTH-1:0]      pair_count
);

    localparam int DY_OFF  = dyLsb(DATA_WIDTH);
    localparam int DZ_OFF  = dzLsb(DATA_WIDTH);
    localparam int R2_OFF  = r2Lsb(DATA_WIDTH);
    localparam int NBR_OFF = neighborLsb(DATA_WIDTH);
    localparam int REF_OFF = refLsb(PARTICLE_ID_WIDTH, DATA_WIDTH);

    logic [IDX_WIDTH-1:0]        r_rrPtr;
    logic [NUM_FILTER-1:0]       r_lastGrant;
    logic                        r_started;
    logic                        r_readValid;
    logic [IDX_WIDTH-1:0]        r_readIdx;
    logic                        r_pairValid;
    logic [IDX_WIDTH-1:0]        r_srcFilter;
    logic [PAIR_WIDTH-1:0]       r_pair;
    logic [PAIR_COUNT_WIDTH-1:0] r_pairCount;

    logic [NUM_FILTER-1:0]       w_request;
    logic [NUM_FILTER-1:0]       w_grant;
    logic [IDX_WIDTH-1:0]        w_grantIdx;
    logic                        w_grantAny;
    logic [IDX_WIDTH-1:0]        w_nextPtr;
    logic [PAIR_WIDTH-1:0]       w_readSlice;

    // Last cycle's grantee is masked out: its empty flag has not caught up with the read yet.
    assign w_request = (r_started && !pipeline_stall)
                     ? (particle_pair_available & ~r_lastGrant)
                     : '0;

    rr_priority_picker #(
        .NUM_REQ    (NUM_FILTER)
    ) u_picker (
        .i_request  (w_request),
        .i_pointer  (r_rrPtr),
        .o_grant    (w_grant),
        .o_grantIdx (w_grantIdx)
    );

    assign w_grantAny = |w_grant;
    assign sel        = w_grant;
    assign w_nextPtr  = (w_grantIdx == IDX_WIDTH'(NUM_FILTER - 1))
                      ? '0
                      : w_grantIdx + IDX_WIDTH'(1);

    always_comb begin
        w_readSlice = '0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            if (r_readIdx == IDX_WIDTH'(i)) begin
                w_readSlice = filter_pair_data[i*PAIR_WIDTH +: PAIR_WIDTH];
            end
        end
    end

    // r_started keeps sel quiet for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_started   <= 1'b0;
            r_rrPtr     <= '0;
            r_lastGrant <= '0;
            r_readValid <= 1'b0;
            r_readIdx   <= '0;
        end else begin
            r_started   <= 1'b1;
            r_lastGrant <= w_grant;
            r_readValid <= w_grantAny;
            r_readIdx   <= w_grantAny ? w_grantIdx : '0;
            if (w_grantAny) begin
                r_rrPtr <= w_nextPtr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pairValid <= 1'b0;
            r_srcFilter <= '0;
            r_pair      <= '0;
            r_pairCount <= '0;
        end else begin
            r_pairValid <= r_readValid;
            r_srcFilter <= r_readValid ? r_readIdx : '0;
            r_pair      <= r_readValid ? w_readSlice : '0;
            if (r_readValid) begin
                r_pairCount <= r_pairCount + PAIR_COUNT_WIDTH'(1);
            end
        end
    end

    assign pair_valid               = r_pairValid;
    assign source_filter            = r_srcFilter;
    assign pair_count               = r_pairCount;
    assign ref_particle_id_out      = r_pair[REF_OFF +: PARTICLE_ID_WIDTH];
    assign neighbor_particle_id_out = r_pair[NBR_OFF +: PARTICLE_ID_WIDTH];
    assign r2_out                   = r_pair[R2_OFF +: DATA_WIDTH];
    assign dz_out                   = r_pair[DZ_OFF +: DATA_WIDTH];
    assign dy_out                   = r_pair[DY_OFF +: DATA_WIDTH];
    assign dx_out                   = r_pair[DX_LSB +: DATA_WIDTH];

endmodule

// File: tb/tb_filter_arbiter.sv
// Self-checking bench for filter_arbiter: directed scenarios plus randomized
// traffic, every cycle compared against a queue-based reference model.
module tb_filter_arbiter;

    localparam int N   = 4;
    localparam int IDW = 20;
    localparam int DW  = 32;
    localparam int PW  = 2 * IDW + 4 * DW;
    localparam int IW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      avail = '0;
    logic              stall = 1'b0;
    logic [N*PW-1:0]   pairData = '0;

    logic [N-1:0]      sel;
    logic [IDW-1:0]    ref_particle_id_out;
    logic [IDW-1:0]    neighbor_particle_id_out;
    logic [DW-1:0]     r2_out;
    logic [DW-1:0]     dx_out;
    logic [DW-1:0]     dy_out;
    logic [DW-1:0]     dz_out;
    logic              pair_valid;
    logic [IW-1:0]     source_filter;
    logic [31:0]       pair_count;

    always #5 clk = ~clk;

    filter_arbiter #(
        .NUM_FILTER               (N),
        .PARTICLE_ID_WIDTH        (IDW),
        .DATA_WIDTH               (DW)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .particle_pair_available  (avail),
        .filter_pair_data         (pairData),
        .sel                      (sel),
        .pipeline_stall           (stall),
        .ref_particle_id_out      (ref_particle_id_out),
        .neighbor_particle_id_out (neighbor_particle_id_out),
        .r2_out                   (r2_out),
        .dx_out                   (dx_out),
        .dy_out                   (dy_out),
        .dz_out                   (dz_out),
        .pair_valid               (pair_valid),
        .source_filter            (source_filter),
        .pair_count               (pair_count)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1ns after the falling edge; data words are fresh every cycle.
    task automatic applyStimulus(input logic [N-1:0] av, input logic st);
        @(negedge clk);
        #1;
        avail = av;
        stall = st;
        for (int w = 0; w < (N * PW + 31) / 32; w++) begin
            pairData = {pairData[N*PW-33:0], 32'($urandom)};
        end
    endtask

    // Reference model: a list of issued reads, each due for capture one cycle after issue.
    typedef struct {
        int     idx;
        longint readCycle;
    } issue_t;

    issue_t        issueQ[$];
    int            mPtr      = 0;
    int            mLast     = -1;
    bit            mStarted  = 1'b0;
    longint        mCycle    = 0;
    bit            expValid  = 1'b0;
    logic [PW-1:0] expPair   = '0;
    int            expIdx    = 0;
    logic [31:0]   mCount    = '0;
    int            presetSeq  = 0;
    int            presetSeen = 0;

    function automatic int modelPick();
        if (!rst || !mStarted || stall) return -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (mPtr + k) % N;
            if (((avail >> j) & N'(1)) != '0 && j != mLast) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            issueQ.delete();
            mPtr       = 0;
            mLast      = -1;
            mStarted   = 1'b0;
            expValid   = 1'b0;
            expPair    = '0;
            expIdx     = 0;
            mCount     = '0;
            presetSeen = presetSeq;
        end else begin
            int     g;
            issue_t it;
            g = modelPick();
            if (presetSeq != presetSeen) begin
                mCount     = 32'hFFFF_FFFF;
                presetSeen = presetSeq;
            end
            expValid = 1'b0;
            expPair  = '0;
            expIdx   = 0;
            if (issueQ.size() > 0 && issueQ[0].readCycle == mCycle) begin
                it       = issueQ.pop_front();
                expValid = 1'b1;
                expPair  = PW'(pairData >> (it.idx * PW));
                expIdx   = it.idx;
                mCount   = mCount + 32'd1;
            end
            if (g >= 0) begin
                issueQ.push_back(issue_t'{idx: g, readCycle: mCycle + 1});
                mPtr  = (g + 1) % N;
                mLast = g;
            end else begin
                mLast = -1;
            end
            mStarted = 1'b1;
            mCycle++;
        end
    end

    int grantCnt [N];
    int validCnt [N];

    always @(negedge clk) begin : compareProc
        int          g;
        logic [N-1:0] expSel;
        logic [31:0] expCnt;
        #3;
        g      = modelPick();
        expSel = (g >= 0) ? N'(1 << g) : '0;
        expCnt = (presetSeq != presetSeen) ? 32'hFFFF_FFFF : mCount;
        checkOutput("sel",           64'(sel),                      64'(expSel));
        checkOutput("pair_valid",    64'(pair_valid),               64'(expValid));
        checkOutput("source_filter", 64'(source_filter),            64'(expIdx));
        checkOutput("ref_id",        64'(ref_particle_id_out),      64'(expPair[PW-1 -: IDW]));
        checkOutput("neighbor_id",   64'(neighbor_particle_id_out), 64'(expPair[PW-IDW-1 -: IDW]));
        checkOutput("r2",            64'(r2_out),                   64'(expPair[4*DW-1 -: DW]));
        checkOutput("dz",            64'(dz_out),                   64'(expPair[3*DW-1 -: DW]));
        checkOutput("dy",            64'(dy_out),                   64'(expPair[2*DW-1 -: DW]));
        checkOutput("dx",            64'(dx_out),                   64'(expPair[DW-1:0]));
        checkOutput("pair_count",    64'(pair_count),               64'(expCnt));
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                grantCnt[i] = 0;
                validCnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sel[i]) grantCnt[i]++;
            end
            if (pair_valid) validCnt[source_filter]++;
        end
    end

    initial begin
        #1_000_000;
        mismatched++;
        $display("[TB] FAIL watchdog: run did not complete, time %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        logic [N-1:0] selOrder [6];
        logic [IW-1:0] srcOrder [5];
        int           pvInWindow;
        int           stallLeft;
        bit           seen;

        selOrder = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        srcOrder = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1111, 1'b0);
            #1;
            checkOutput("reset_sel",        64'(sel),        64'(0));
            checkOutput("reset_pair_valid", 64'(pair_valid), 64'(0));
            checkOutput("reset_pair_count", 64'(pair_count), 64'(0));
        end

        // All four filters busy from reset release.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 1'b0);
            if (k == 0) rst = 1'b1;
            #1;
            if (k < 6) checkOutput("order_sel", 64'(sel), 64'(selOrder[k]));
            if (k >= 3) begin
                checkOutput("order_valid", 64'(pair_valid),    64'(1));
                checkOutput("order_src",   64'(source_filter), 64'(srcOrder[k-3]));
            end
            if (k == 7) checkOutput("order_count", 64'(pair_count), 64'(5));
        end

        // Six-cycle stall under full load.
        pvInWindow = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b1111, 1'b1);
            #1;
            checkOutput("stall_sel", 64'(sel), 64'(0));
            if (pair_valid) pvInWindow++;
        end
        checkOutput("stall_window_pairs", 64'(pvInWindow), 64'(2));
        applyStimulus(4'b1111, 1'b0);
        #1;
        checkOutput("stall_resume", 64'(|sel), 64'(1));

        // Single requester: grants on alternate cycles only.
        for (int k = 0; k < 3; k++) applyStimulus(4'b0000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0001, 1'b0);
            #1;
            checkOutput("single_sel", 64'(sel), 64'((k % 2 == 0) ? 1 : 0));
        end

        // Pointer wrap from 3 to 0.
        for (int k = 0; k < 3; k++) applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        #1;
        checkOutput("wrap_setup_sel", 64'(sel), 64'(4'b0100));
        applyStimulus(4'b1001, 1'b0);
        #1;
        checkOutput("wrap_sel_a", 64'(sel), 64'(4'b1000));
        applyStimulus(4'b1001, 1'b0);
        #1;
        checkOutput("wrap_sel_b", 64'(sel), 64'(4'b0001));
        applyStimulus(4'b0000, 1'b0);
        #1;
        checkOutput("wrap_rr_ptr", 64'(dut.r_rrPtr), 64'(1));

        // Reset pulse with two pairs in flight.
        for (int k = 0; k < 4; k++) applyStimulus(4'b1111, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("midreset_sel",   64'(sel),         64'(0));
        checkOutput("midreset_valid", 64'(pair_valid),  64'(0));
        checkOutput("midreset_count", 64'(pair_count),  64'(0));
        checkOutput("midreset_dx",    64'(dx_out),      64'(0));
        checkOutput("midreset_ref",   64'(ref_particle_id_out), 64'(0));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0110, 1'b0);
            if (k == 0) rst = 1'b1;
            #1;
            if (k == 0) checkOutput("postreset_sel0", 64'(sel), 64'(0));
            if (k == 1) checkOutput("postreset_sel1", 64'(sel), 64'(4'b0010));
            if (k < 3)  checkOutput("postreset_no_stale", 64'(pair_valid), 64'(0));
            if (k == 3) checkOutput("postreset_src", 64'(source_filter), 64'(1));
        end

        // Counter wrap from all-ones.
        for (int k = 0; k < 4; k++) applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        #1;
        force dut.r_pairCount = 32'hFFFF_FFFF;
        presetSeq++;
        #1;
        release dut.r_pairCount;
        applyStimulus(4'b0001, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            applyStimulus(4'b0000, 1'b0);
            #1;
            if (pair_valid) begin
                seen = 1'b1;
                checkOutput("count_wrap", 64'(pair_count), 64'(0));
            end
        end
        checkOutput("count_wrap_pair_seen", 64'(seen), 64'(1));

        // Randomized traffic with stall bursts.
        stallLeft = 0;
        for (int c = 0; c < 1500; c++) begin
            logic [N-1:0] av;
            av = N'($urandom);
            if ($urandom_range(0, 3) == 0) av = N'(1 << $urandom_range(0, N - 1));
            if (stallLeft == 0 && $urandom_range(0, 19) == 0) stallLeft = $urandom_range(1, 8);
            applyStimulus(av, stallLeft > 0);
            if (stallLeft > 0) stallLeft--;
        end

        for (int k = 0; k < 6; k++) applyStimulus(4'b0000, 1'b0);
        #4;
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("scoreboard_filter%0d", i), 64'(validCnt[i]), 64'(grantCnt[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/filter_arbiter.md
FILTER_ARBITER -- requirements
Module: filter_arbiter

Interface
REQ-001 Parameter NUM_FILTER, default 4: number of filters sharing one force pipeline (2..8).
REQ-002 Parameter PARTICLE_ID_WIDTH, default 20: particle ID width.
REQ-003 Parameter DATA_WIDTH, default 32: IEEE single-precision word width.
REQ-004 Derived constant PAIR_WIDTH = 2*PARTICLE_ID_WIDTH + 4*DATA_WIDTH. Filter pair word, MSB to LSB: {ref_id, neighbor_id, r2, dz, dy, dx}.
REQ-005 Port clk  input  1  single clock, all logic on its rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-low.
REQ-007 Port particle_pair_available  input  NUM_FILTER  bit i is the non-empty flag of filter i's buffer.
REQ-008 Port filter_pair_data  input  NUM_FILTER*PAIR_WIDTH  buffer read data; slice i belongs to filter i.
REQ-009 Port sel  output  NUM_FILTER  one-hot read request, one bit per filter buffer.
REQ-010 Port pipeline_stall  input  1  force-pipeline hold request.
REQ-011 Port ref_particle_id_out, neighbor_particle_id_out  output  PARTICLE_ID_WIDTH each  IDs of the issued pair.
REQ-012 Port r2_out, dx_out, dy_out, dz_out  output  DATA_WIDTH each  fields of the issued pair.
REQ-013 Port pair_valid  output  1  the output fields hold a valid pair this cycle.
REQ-014 Port source_filter  output  $clog2(NUM_FILTER)  index of the filter that supplied the issued pair.
REQ-015 Port pair_count  output  32  running count of issued pairs.

Function
REQ-016 sel SHALL be at most one-hot and SHALL be decoded from registered state plus particle_pair_available.
REQ-017 Eligibility: filter i is eligible in cycle t if all of the following hold:
- particle_pair_available[i]=1
- pipeline_stall=0
- filter i was not granted in cycle t-1. This blocks a double read while the buffer empty flag is still stale.
REQ-018 Round-robin grant: among eligible filters, grant the first one at or after rr_ptr, searching upward with wrap from NUM_FILTER-1 to 0.
REQ-019 rr_ptr SHALL update to (granted index + 1) mod NUM_FILTER on each grant. With no grant, rr_ptr SHALL hold.
REQ-020 Two-stage pipeline:
- Read stage: the cycle after sel[i], the arbiter registers slice i of filter_pair_data together with index i.
- Output stage: one further cycle later, pair_valid=1 with that slice on the output ports.
- Total latency from sel to pair_valid is 2 cycles.
REQ-021 With a single requesting filter, a grant SHALL be issued at most every other cycle. With two or more eligible requesters, a grant SHALL be issued every cycle.
REQ-022 Stall: while pipeline_stall=1, no new sel is issued. Reads already in flight complete, so at most 2 pairs appear after stall rises. Issue resumes in the cycle stall falls.
REQ-023 When pair_valid=0, the output data ports SHALL be driven to 0.
REQ-024 pair_count SHALL increment on every pair_valid cycle and SHALL wrap from 2^32-1 to 0.
REQ-025 A filter that deasserts available in the same cycle it would be granted is not granted; there is no lookahead.

Reset
REQ-026 With rst low, the following SHALL clear asynchronously:
- sel = 0 and pair_valid = 0.
- All data outputs = 0, source_filter = 0, pair_count = 0.
- rr_ptr = 0, the last-grant mask and the in-flight valid bit.
REQ-027 Reset mid-operation SHALL discard in-flight pairs. After release, the first grant SHALL follow the rr_ptr=0 rule.
REQ-028 The block SHALL issue no sel in the first cycle after reset release.

Structure
REQ-029 NUM_FILTER default, PAIR_WIDTH and the pair field-offset constants SHALL reside in the shared filter package used by the filter and force-pipeline blocks.
REQ-030 The round-robin find-first SHALL be a separate combinational sub-module rr_priority_picker with the following ports:
- Inputs: request vector, pointer.
- Outputs: one-hot grant and grant index.

Verification
REQ-031 Single filter: available=4'b0001 held, other inputs quiet -> sel=0001 on alternate cycles; pair_valid 2 cycles after each sel with matching data; no consecutive sel to filter 0.
REQ-032 All four filters: available=4'b1111 after reset -> grant order 0,1,2,3,0 on consecutive cycles; source_filter follows the same order 2 cycles later; pair_count=5 after 5 valid cycles.
REQ-033 Stall: stall asserted for 6 cycles during full load -> sel=0 throughout; pair_valid on at most 2 cycles of the window; no pair lost or duplicated against a per-filter scoreboard.
REQ-034 Wrap: available=4'b1001 with rr_ptr=3 -> grant 3 then 0; rr_ptr ends at 1.
REQ-035 Reset: rst pulsed low 1 cycle while 2 pairs are in flight -> outputs 0 immediately; no stale pair_valid after release; first grant goes to the lowest available index.
REQ-036 Counter: pair_count preset to 32'hFFFFFFFF via force, then one pair issued -> pair_count=0.
